// File: rtl/half_adder_pkg.sv
// Shared constants for the half-adder lane array.
// Latency: none (declarations only).
// Backpressure: none.
package half_adder_pkg;

    // Default lane count when a user does not override WIDTH.
    localparam int HA_WIDTH_DEFAULT = 1;

    // Largest lane count the array is intended to be built with.
    localparam int HA_MAX_LANES = 64;

    // True when a requested lane count lies in the supported range.
    function automatic bit ha_lanes_ok(input int lanes);
        return (lanes >= 1) && (lanes <= HA_MAX_LANES);
    endfunction

endpackage

// File: rtl/half_adder_if.sv
// Operand/result bundle for the half-adder lane array.
// Latency: none (wires only).
// Backpressure: none; operands are sampled unconditionally.
interface half_adder_if
    import half_adder_pkg::*;
#(
    parameter int WIDTH = HA_WIDTH_DEFAULT
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;

    // Producer of operands, consumer of results.
    modport master (
        output a,
        output b,
        input  s,
        input  c
    );

    // The adder itself: consumes operands, produces results.
    modport slave (
        input  a,
        input  b,
        output s,
        output c
    );

endinterface

// File: rtl/half_adder_cell.sv
// Single-lane half adder: sum = a ^ b, carry = a & b.
// Latency: purely combinational.
// Backpressure: none.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Sum and carry can never both be high: that would need a^b and a&b at once.
    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with optional output registers.
// Latency: 1 cycle when REGISTERED=1, combinational when REGISTERED=0.
// Backpressure: none; a/b are captured on every rising edge.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH      = HA_WIDTH_DEFAULT,
    parameter bit REGISTERED = 1'b1
)
(
    input  logic         clk,
    input  logic         rst,
    half_adder_if.slave  bus
);

    logic [WIDTH-1:0] sum_comb;
    logic [WIDTH-1:0] carry_comb;

    // One cell per lane; lanes share nothing, so there is no carry chain.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a (bus.a[i]),
            .b (bus.b[i]),
            .s (sum_comb[i]),
            .c (carry_comb[i])
        );
    end

    if (REGISTERED) begin : g_reg
        logic [WIDTH-1:0] s_q;
        logic [WIDTH-1:0] c_q;

        // Capture lane results each edge; the async clear wins over any edge
        // that arrives while rst is still high.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q <= '0;
                c_q <= '0;
            end else begin
                s_q <= sum_comb;
                c_q <= carry_comb;
            end
        end

        assign bus.s = s_q;
        assign bus.c = c_q;
    end else begin : g_comb
        // Clock and reset have no role in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst};

        assign bus.s = sum_comb;
        assign bus.c = carry_comb;
    end

endmodule

// File: tb/tb_half_adder.sv
module tb_half_adder;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    half_adder_if #(.WIDTH(1)) if1 ();
    half_adder_if #(.WIDTH(8)) if8 ();
    half_adder_if #(.WIDTH(4)) if4 ();

    half_adder #(.WIDTH(1), .REGISTERED(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    half_adder #(.WIDTH(8), .REGISTERED(1'b1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    half_adder #(.WIDTH(4), .REGISTERED(1'b0)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    // 20 ns period, rising edges at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each entry is {a, b, expected s, expected c} for the one-lane sequence.
    logic [3:0] seq [4];
    logic [1:0] prev_sc;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        seq[0] = 4'b1010;
        seq[1] = 4'b1101;
        seq[2] = 4'b0110;
        seq[3] = 4'b0000;

        rst    = 1'b0;
        if1.a  = 1'b0;
        if1.b  = 1'b0;
        if8.a  = 8'h00;
        if8.b  = 8'h00;
        if4.a  = 4'h0;
        if4.b  = 4'h0;

        // Reset asserted mid-cycle, before any rising edge.
        #3 rst = 1'b1;
        #1;
        check("rst_async_s1", 8'(if1.s), 8'h00);
        check("rst_async_c1", 8'(if1.c), 8'h00);
        check("rst_async_s8", if8.s, 8'h00);
        check("rst_async_c8", if8.c, 8'h00);

        // Ones on the inputs while held in reset; combinational lanes ignore rst.
        if1.a = 1'b1;
        if1.b = 1'b1;
        if8.a = 8'hFF;
        if8.b = 8'hFF;
        if4.a = 4'b1010;
        if4.b = 4'b0110;
        #1;
        check("comb_rst_hi_s4", 8'(if4.s), 8'h0C);
        check("comb_rst_hi_c4", 8'(if4.c), 8'h02);

        // Edge while rst is high leaves outputs at zero.
        @(posedge clk);
        #1;
        check("rst_edge_s1", 8'(if1.s), 8'h00);
        check("rst_edge_c1", 8'(if1.c), 8'h00);
        check("rst_edge_c8", if8.c, 8'h00);

        // Release between edges: nothing loads until the next edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel_s1", 8'(if1.s), 8'h00);
        check("rst_rel_c1", 8'(if1.c), 8'h00);
        check("comb_rst_lo_s4", 8'(if4.s), 8'h0C);
        check("comb_rst_lo_c4", 8'(if4.c), 8'h02);

        @(posedge clk);
        #1;
        check("first_load_s1", 8'(if1.s), 8'h00);
        check("first_load_c1", 8'(if1.c), 8'h01);
        check("ones_s8", if8.s, 8'h00);
        check("ones_c8", if8.c, 8'hFF);
        prev_sc = 2'b01;

        // Sequence: inputs change 5 ns after each edge, outputs move only on edges.
        for (int i = 0; i < 4; i++) begin
            #4;
            if1.a = seq[i][3];
            if1.b = seq[i][2];
            #1;
            check($sformatf("seq%0d_hold_s", i), 8'(if1.s), 8'(prev_sc[1]));
            check($sformatf("seq%0d_hold_c", i), 8'(if1.c), 8'(prev_sc[0]));
            @(posedge clk);
            #1;
            check($sformatf("seq%0d_s", i), 8'(if1.s), 8'(seq[i][1]));
            check($sformatf("seq%0d_c", i), 8'(if1.c), 8'(seq[i][0]));
            prev_sc = seq[i][1:0];
        end

        // Toggle a several times between edges, settling at a=1, b=1.
        #4 if1.a = 1'b1;
        if8.a = 8'hF0;
        if8.b = 8'hCC;
        #2 if1.a = 1'b0;
        #2 if1.a = 1'b1;
        #2 if1.b = 1'b1;
        #2 if1.a = 1'b0;
        #2 if1.a = 1'b1;
        #1;
        check("toggle_hold_s1", 8'(if1.s), 8'h00);
        check("toggle_hold_c1", 8'(if1.c), 8'h00);
        check("w8_hold_s8", if8.s, 8'h00);
        check("w8_hold_c8", if8.c, 8'hFF);
        @(posedge clk);
        #1;
        check("toggle_s1", 8'(if1.s), 8'h00);
        check("toggle_c1", 8'(if1.c), 8'h01);
        check("w8_f0cc_s8", if8.s, 8'h3C);
        check("w8_f0cc_c8", if8.c, 8'hC0);

        // Latch s=1, then clear asynchronously mid-cycle.
        #4 if1.b = 1'b0;
        if8.a = 8'h55;
        if8.b = 8'hAA;
        @(posedge clk);
        #1;
        check("pre_clr_s1", 8'(if1.s), 8'h01);
        check("pre_clr_c1", 8'(if1.c), 8'h00);
        check("w8_55aa_s8", if8.s, 8'hFF);
        check("w8_55aa_c8", if8.c, 8'h00);
        #4 rst = 1'b1;
        #1;
        check("mid_clr_s1", 8'(if1.s), 8'h00);
        check("mid_clr_s8", if8.s, 8'h00);
        #2 rst = 1'b0;
        #1;
        check("post_clr_s1", 8'(if1.s), 8'h00);
        @(posedge clk);
        #1;
        check("reload_s1", 8'(if1.s), 8'h01);
        check("reload_c1", 8'(if1.c), 8'h00);
        check("reload_s8", if8.s, 8'hFF);

        // Further combinational vectors, checked mid-cycle.
        #4 if4.a = 4'hF;
        if4.b = 4'hF;
        #1;
        check("comb_ones_s4", 8'(if4.s), 8'h00);
        check("comb_ones_c4", 8'(if4.c), 8'h0F);
        if4.a = 4'h0;
        if4.b = 4'hF;
        #1;
        check("comb_0f_s4", 8'(if4.s), 8'h0F);
        check("comb_0f_c4", 8'(if4.c), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
